// File: rtl/bp_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : bp_pkg
//  Description : Shared types and constants for the branch target buffer:
//                2-bit direction counter encoding and allocation strengths.
//  Revision    : 1.0 - initial release
// ============================================================================
package bp_pkg;

  // Direction counter: MSB set means "predict taken".
  typedef enum logic [1:0] {
    BP_STRONG_NT = 2'd0,
    BP_WEAK_NT   = 2'd1,
    BP_WEAK_T    = 2'd2,
    BP_STRONG_T  = 2'd3
  } e_bp_ctr;

  // Strength given to a freshly allocated entry.
  localparam e_bp_ctr BP_ALLOC_COND   = BP_WEAK_T;
  localparam e_bp_ctr BP_ALLOC_UNCOND = BP_STRONG_T;

  // True when the counter state predicts taken.
  function automatic logic bp_predicts_taken(input e_bp_ctr c);
    return (c == BP_WEAK_T) || (c == BP_STRONG_T);
  endfunction

endpackage
`default_nettype wire

// File: rtl/bp_sat_counter.sv
`default_nettype none
// ============================================================================
//  Module      : bp_sat_counter
//  Description : Next-state function of a 2-bit saturating direction counter
//                for one resolved branch. On a miss the result is the
//                allocation strength (only meaningful when the branch was
//                taken and an entry is being allocated).
//  Revision    : 1.0 - initial release
// ============================================================================
module bp_sat_counter
  import bp_pkg::*;
(
  input  e_bp_ctr ctr_i,
  input  logic    taken_i,
  input  logic    uncond_i,
  input  logic    hit_i,
  output e_bp_ctr ctr_o
);

  // Saturating step on a conditional hit, forced strong-T on jumps,
  // allocation strength on a miss.
  always_comb begin
    ctr_o = ctr_i;
    if (!hit_i) begin
      ctr_o = uncond_i ? BP_ALLOC_UNCOND : BP_ALLOC_COND;
    end else if (uncond_i) begin
      ctr_o = BP_STRONG_T;
    end else if (taken_i) begin
      case (ctr_i)
        BP_STRONG_NT: ctr_o = BP_WEAK_NT;
        BP_WEAK_NT:   ctr_o = BP_WEAK_T;
        BP_WEAK_T:    ctr_o = BP_STRONG_T;
        default:      ctr_o = BP_STRONG_T;
      endcase
    end else begin
      case (ctr_i)
        BP_STRONG_T:  ctr_o = BP_WEAK_T;
        BP_WEAK_T:    ctr_o = BP_WEAK_NT;
        BP_WEAK_NT:   ctr_o = BP_STRONG_NT;
        default:      ctr_o = BP_STRONG_NT;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/branch_predictor.sv
`default_nettype none
// ============================================================================
//  Module      : branch_predictor
//  Description : Direct-mapped fetch-side branch target buffer with 2-bit
//                saturating direction counters. Zero-latency lookup from
//                registered state; learns from writeback branch updates.
//                Optional statistics counters enabled by macro BP_STATS_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module branch_predictor
  import bp_pkg::*;
#(
  parameter int ENTRIES = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] fetch_pc,
  output logic [31:0] pred_next_pc,
  output logic        pred_taken,
  output logic        pred_hit,
  input  logic        branch_update_valid,
  input  logic        branch_update_taken,
  input  logic        branch_update_mispredicted,
  input  logic        branch_update_unconditional,
  input  logic [31:0] branch_update_addr,
  input  logic [31:0] branch_update_target
`ifdef BP_STATS_EN
  ,
  output logic [31:0] stat_updates,
  output logic [31:0] stat_mispredicts,
  output logic [31:0] stat_allocs
`endif
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = 30 - IDX_W;

  // Table storage: only the valid vector is reset.
  logic [ENTRIES-1:0] valid_q, valid_d;
  logic [TAG_W-1:0]   tag_q    [ENTRIES];
  logic [31:0]        target_q [ENTRIES];
  e_bp_ctr            ctr_q    [ENTRIES];

  // Lookup side
  logic [IDX_W-1:0] fetch_idx;
  logic [TAG_W-1:0] fetch_tag;

  assign fetch_idx    = fetch_pc[IDX_W+1:2];
  assign fetch_tag    = fetch_pc[31:IDX_W+2];
  assign pred_hit     = valid_q[fetch_idx] && (tag_q[fetch_idx] == fetch_tag);
  assign pred_taken   = pred_hit && bp_predicts_taken(ctr_q[fetch_idx]);
  assign pred_next_pc = pred_taken ? target_q[fetch_idx] : (fetch_pc + 32'd4);

  // Update side
  logic [IDX_W-1:0] upd_idx;
  logic [TAG_W-1:0] upd_tag;
  logic             upd_hit;
  logic             upd_alloc;
  logic             upd_ctr_we;
  logic             upd_tgt_we;
  e_bp_ctr          upd_ctr_next;

  assign upd_idx    = branch_update_addr[IDX_W+1:2];
  assign upd_tag    = branch_update_addr[31:IDX_W+2];
  assign upd_hit    = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);
  assign upd_alloc  = branch_update_valid && !upd_hit && branch_update_taken;
  assign upd_ctr_we = branch_update_valid && (upd_hit || branch_update_taken);
  assign upd_tgt_we = branch_update_valid &&
                      (branch_update_taken || (upd_hit && branch_update_unconditional));

  bp_sat_counter u_sat_counter (
    .ctr_i    (ctr_q[upd_idx]),
    .taken_i  (branch_update_taken),
    .uncond_i (branch_update_unconditional),
    .hit_i    (upd_hit),
    .ctr_o    (upd_ctr_next)
  );

  // Valid bit set on allocation; entries are never invalidated except by reset.
  always_comb begin
    valid_d = valid_q;
    if (upd_alloc) valid_d[upd_idx] = 1'b1;
  end

  // Valid vector with asynchronous clear so reset wins over an in-flight update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) valid_q <= '0;
    else        valid_q <= valid_d;
  end

  // Tag/target/counter arrays: no reset, guarded by the valid vector.
  always_ff @(posedge clk) begin
    if (upd_alloc)  tag_q[upd_idx]    <= upd_tag;
    if (upd_ctr_we) ctr_q[upd_idx]    <= upd_ctr_next;
    if (upd_tgt_we) target_q[upd_idx] <= branch_update_target;
  end

`ifdef BP_STATS_EN
  logic [31:0] stat_updates_q, stat_mispredicts_q, stat_allocs_q;

  // Free-running event counters, wrapping at 2^32.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_updates_q     <= '0;
      stat_mispredicts_q <= '0;
      stat_allocs_q      <= '0;
    end else begin
      if (branch_update_valid)
        stat_updates_q <= stat_updates_q + 32'd1;
      if (branch_update_valid && branch_update_mispredicted)
        stat_mispredicts_q <= stat_mispredicts_q + 32'd1;
      if (upd_alloc)
        stat_allocs_q <= stat_allocs_q + 32'd1;
    end
  end

  assign stat_updates     = stat_updates_q;
  assign stat_mispredicts = stat_mispredicts_q;
  assign stat_allocs      = stat_allocs_q;
`endif

  // Byte-offset bits carry no index/tag information; the mispredict flag
  // only matters for statistics.
  logic unused_inputs;
  assign unused_inputs = ^{fetch_pc[1:0], branch_update_addr[1:0],
                           branch_update_mispredicted};

endmodule
`default_nettype wire

// File: tb/tb_branch_predictor.sv
`default_nettype none
// ============================================================================
//  Module      : tb_branch_predictor
//  Description : Self-checking bench for branch_predictor: directed scenarios
//                followed by randomized updates/lookups against a behavioural
//                table model. Stats checks compiled when BP_STATS_EN is set.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_branch_predictor;

  localparam int ENTRIES = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] fetch_pc;
  logic [31:0] pred_next_pc;
  logic        pred_taken;
  logic        pred_hit;
  logic        upd_valid, upd_taken, upd_mispred, upd_uncond;
  logic [31:0] upd_addr, upd_target;
`ifdef BP_STATS_EN
  logic [31:0] stat_updates, stat_mispredicts, stat_allocs;
`endif

  always #5 clk = ~clk;

  branch_predictor #(.ENTRIES(ENTRIES)) dut (
    .clk                         (clk),
    .rst_n                       (rst_n),
    .fetch_pc                    (fetch_pc),
    .pred_next_pc                (pred_next_pc),
    .pred_taken                  (pred_taken),
    .pred_hit                    (pred_hit),
    .branch_update_valid         (upd_valid),
    .branch_update_taken         (upd_taken),
    .branch_update_mispredicted  (upd_mispred),
    .branch_update_unconditional (upd_uncond),
    .branch_update_addr          (upd_addr),
    .branch_update_target        (upd_target)
`ifdef BP_STATS_EN
    ,
    .stat_updates                (stat_updates),
    .stat_mispredicts            (stat_mispredicts),
    .stat_allocs                 (stat_allocs)
`endif
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit          m_valid  [ENTRIES];
  logic [31:0] m_tag    [ENTRIES];
  logic [31:0] m_target [ENTRIES];
  int          m_ctr    [ENTRIES];
  int unsigned m_upd, m_mis, m_alloc;

  function automatic int idx_of(input logic [31:0] pc);
    return int'((pc / 4) % ENTRIES);
  endfunction

  function automatic logic [31:0] tag_of(input logic [31:0] pc);
    return pc / (4 * ENTRIES);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < ENTRIES; i++) m_valid[i] = 1'b0;
    m_upd = 0; m_mis = 0; m_alloc = 0;
  endtask

  task automatic model_update();
    int  i;
    bit  hit;
    if (!upd_valid) return;
    m_upd++;
    if (upd_mispred) m_mis++;
    i   = idx_of(upd_addr);
    hit = m_valid[i] && (m_tag[i] == tag_of(upd_addr));
    if (hit) begin
      if (upd_uncond) begin
        m_ctr[i] = 3; m_target[i] = upd_target;
      end else if (upd_taken) begin
        m_ctr[i] = (m_ctr[i] + 1 > 3) ? 3 : m_ctr[i] + 1;
        m_target[i] = upd_target;
      end else begin
        m_ctr[i] = (m_ctr[i] - 1 < 0) ? 0 : m_ctr[i] - 1;
      end
    end else if (upd_taken) begin
      m_valid[i] = 1'b1; m_tag[i] = tag_of(upd_addr);
      m_target[i] = upd_target; m_ctr[i] = upd_uncond ? 3 : 2;
      m_alloc++;
    end
  endtask

  task automatic check_pred(input string tag);
    int          i;
    bit          e_hit, e_taken;
    logic [31:0] e_next;
    i       = idx_of(fetch_pc);
    e_hit   = m_valid[i] && (m_tag[i] == tag_of(fetch_pc));
    e_taken = e_hit && (m_ctr[i] >= 2);
    e_next  = e_taken ? m_target[i] : fetch_pc + 32'd4;
    chk({tag, "_hit"},   {31'd0, pred_hit},   {31'd0, e_hit});
    chk({tag, "_taken"}, {31'd0, pred_taken}, {31'd0, e_taken});
    chk({tag, "_next"},  pred_next_pc,        e_next);
  endtask

  // One clock: check lookup (pre-update state), take the edge, advance model.
  task automatic tick(input string tag);
    #2;
    check_pred(tag);
    @(posedge clk);
    model_update();
    #1;
    upd_valid = 1'b0;
  endtask

  task automatic do_upd(input logic [31:0] addr, input logic taken, input logic [31:0] tgt,
                        input logic uncond, input logic mis);
    upd_valid = 1'b1; upd_addr = addr; upd_taken = taken;
    upd_target = tgt; upd_uncond = uncond; upd_mispred = mis;
    tick("upd");
  endtask

  // Directed lookup against fixed expected values (no clock advance).
  task automatic expect_pred(input string tag, input logic [31:0] pc, input logic hit,
                             input logic taken, input logic [31:0] next);
    fetch_pc = pc;
    #2;
    chk({tag, "_hit"},   {31'd0, pred_hit},   {31'd0, hit});
    chk({tag, "_taken"}, {31'd0, pred_taken}, {31'd0, taken});
    chk({tag, "_next"},  pred_next_pc,        next);
  endtask

  function automatic logic [31:0] rand_pc();
    logic [31:0] pc;
    if ($urandom_range(0, 19) == 0) pc = 32'hFFFF_FFC0;
    else                            pc = 32'($urandom_range(0, 3)) * 32'h400;
    return pc + 32'($urandom_range(0, 15)) * 4 + 32'($urandom_range(0, 3));
  endfunction

  initial begin
    rst_n = 1'b0; fetch_pc = 32'h100;
    upd_valid = 0; upd_taken = 0; upd_mispred = 0; upd_uncond = 0;
    upd_addr = 0; upd_target = 0;
    model_reset();
    #12 rst_n = 1'b1;
    @(posedge clk); #1;

    // Reset state
    expect_pred("reset", 32'h100, 0, 0, 32'h104);

    // Allocate: same-cycle lookup sees old state, next cycle sees the entry
    fetch_pc = 32'h100;
    upd_valid = 1; upd_addr = 32'h100; upd_taken = 1; upd_target = 32'h200;
    upd_uncond = 0; upd_mispred = 0;
    #2 chk("alloc_same_cycle_next", pred_next_pc, 32'h104);
    @(posedge clk); model_update(); #1 upd_valid = 0;
    expect_pred("alloc", 32'h100, 1, 1, 32'h200);

    // Hysteresis
    do_upd(32'h100, 0, 32'h0, 0, 1);
    expect_pred("weak_nt", 32'h100, 1, 0, 32'h104);
    do_upd(32'h100, 1, 32'h200, 0, 0);
    do_upd(32'h100, 1, 32'h200, 0, 0);
    do_upd(32'h100, 0, 32'h0, 0, 0);
    expect_pred("hyst", 32'h100, 1, 1, 32'h200);

    // Aliasing on index 0
    do_upd(32'h500, 1, 32'h600, 0, 0);
    expect_pred("alias_old", 32'h100, 0, 0, 32'h104);
    expect_pred("alias_new", 32'h500, 1, 1, 32'h600);

    // Not-taken miss and PC wrap
    do_upd(32'h300, 0, 32'h900, 0, 0);
    expect_pred("nt_miss", 32'h300, 0, 0, 32'h304);
    expect_pred("wrap", 32'hFFFF_FFFC, 0, 0, 32'h0000_0000);

    // Unconditional allocate then conditional not-taken keeps weak-T
    do_upd(32'h204, 1, 32'h1234, 1, 0);
    do_upd(32'h204, 0, 32'h0, 0, 0);
    expect_pred("jal_alloc", 32'h204, 1, 1, 32'h1234);

    // Async clear, and reset overriding an in-flight allocation
    fetch_pc = 32'h500;
    upd_valid = 1; upd_addr = 32'h700; upd_taken = 1; upd_target = 32'hABC;
    upd_uncond = 0; upd_mispred = 0;
    #2 rst_n = 1'b0;
    #1 chk("async_clear_hit", {31'd0, pred_hit}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1; upd_valid = 0;
    model_reset();
    expect_pred("rst_mid_upd", 32'h700, 0, 0, 32'h704);

`ifdef BP_STATS_EN
    do_upd(32'h100, 1, 32'h200, 0, 1);
    do_upd(32'h104, 1, 32'h300, 0, 0);
    do_upd(32'h100, 0, 32'h0,   0, 0);
    #2;
    chk("stat_updates",     stat_updates,     32'd3);
    chk("stat_mispredicts", stat_mispredicts, 32'd1);
    chk("stat_allocs",      stat_allocs,      32'd2);
    rst_n = 1'b0;
    #1;
    chk("stat_updates_rst",     stat_updates,     32'd0);
    chk("stat_mispredicts_rst", stat_mispredicts, 32'd0);
    chk("stat_allocs_rst",      stat_allocs,      32'd0);
    #2 rst_n = 1'b1;
    model_reset();
    @(posedge clk); #1;
`endif

    // Randomized traffic against the model
    for (int n = 0; n < 400; n++) begin
      fetch_pc = rand_pc();
      if ($urandom_range(0, 9) < 6) begin
        upd_valid   = 1'b1;
        upd_addr    = ($urandom_range(0, 3) == 0) ? fetch_pc : rand_pc();
        upd_taken   = 1'($urandom_range(0, 1));
        upd_uncond  = ($urandom_range(0, 4) == 0);
        upd_mispred = 1'($urandom_range(0, 1));
        upd_target  = $urandom;
      end
      tick("rand");
    end

`ifdef BP_STATS_EN
    #2;
    chk("stat_updates_rand",     stat_updates,     m_upd);
    chk("stat_mispredicts_rand", stat_mispredicts, m_mis);
    chk("stat_allocs_rand",      stat_allocs,      m_alloc);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
